// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative radix-2 shift-add multiply controller for the
// execute stage. It accepts MUL/MLA/UMULL/UMLAL/SMULL/SMLAL commands through a
// start/done handshake and holds the pipeline through stall until the
// 32/64-bit result is ready.
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | WIDTH shift-add iterations, counter 0..WIDTH-1
//   ADJ    | sign correction, accumulate, result/flag update
//   DONE   | done pulse; a new start may be accepted here
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start, cmd          request and command (000 MUL, 001 MLA, 100 UMULL,
//                       101 UMLAL, 110 SMULL, 111 SMLAL, others illegal)
//   a, b                multiplicand / multiplier
//   acc_lo, acc_hi      accumulator words
//   flush               synchronous abort from the pipeline
//   busy, done, stall   handshake / pipeline hold
//   err                 pulses with done for an illegal cmd
//   result_lo/hi        result words, flag_n/flag_z result flags
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             err,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ADJ,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               fn_q, fn_d;
  logic               fz_q, fz_d;

  logic               can_start;
  logic               accept;
  logic               in_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               is_long;
  logic               is_accum;
  logic               is_illegal;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_sgn;
  logic [2*WIDTH-1:0] acc_ext;
  logic [2*WIDTH-1:0] total;

  assign can_start  = (state_q == S_IDLE) || (state_q == S_DONE);
  // flush beats a simultaneous start
  assign accept     = start && !flush && can_start;

  // Magnitudes are kept as unsigned WIDTH-bit values, so the most negative
  // operand becomes 2^(WIDTH-1) without overflowing.
  assign in_signed  = cmd[2] && cmd[1];
  assign a_mag      = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag      = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  assign is_long    = cmd_q[2];
  assign is_accum   = cmd_q[0];
  assign is_illegal = (cmd_q[2:1] == 2'b01);

  // 33-bit add into the upper half keeps the carry before the right shift
  assign sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign prod_sgn = neg_q ? (~prod_q + 1'b1) : prod_q;
  assign acc_ext  = !is_accum ? '0 :
                    is_long   ? {acc_hi_q, acc_lo_q} :
                                {{WIDTH{1'b0}}, acc_lo_q};
  assign total    = prod_sgn + acc_ext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    fn_d     = fn_q;
    fz_d     = fz_q;

    if (accept) begin
      cmd_d    = cmd;
      mcand_d  = a_mag;
      mplier_d = b_mag;
      acc_lo_d = acc_lo;
      acc_hi_d = acc_hi;
      neg_d    = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      prod_d   = '0;
      cnt_d    = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          prod_d   = {sum, prod_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_ADJ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ADJ: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_DONE;
          if (is_illegal) begin
            res_lo_d = '0;
            res_hi_d = '0;
            fn_d     = 1'b0;
            fz_d     = 1'b0;
          end else if (is_long) begin
            res_lo_d = total[WIDTH-1:0];
            res_hi_d = total[2*WIDTH-1:WIDTH];
            fn_d     = total[2*WIDTH-1];
            fz_d     = (total == '0);
          end else begin
            res_lo_d = total[WIDTH-1:0];
            res_hi_d = '0;
            fn_d     = total[WIDTH-1];
            fz_d     = (total[WIDTH-1:0] == '0);
          end
        end
      end
      S_DONE: begin
        state_d = accept ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      fn_q     <= fn_d;
      fz_q     <= fz_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_ADJ);
  assign done      = (state_q == S_DONE);
  assign err       = done && is_illegal;
  assign stall     = busy || (start && can_start);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flag_n    = fn_q;
  assign flag_z    = fz_q;

endmodule
